// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Hits are served combinationally; misses stall the pipeline while lines move to/from memory.
module dcache_ctrl #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_BITS  = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 p1_req_i,
    input  logic                 p1_write_i,
    input  logic [31:0]          p1_addr_i,
    input  logic [31:0]          p1_data_i,
    output logic [31:0]          p1_data_o,
    output logic                 p1_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_BITS  = $clog2(NUM_LINES);
    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
    localparam int WSEL_BITS = OFF_BITS - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]  data_q [NUM_LINES];
    logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
    logic [IDX_BITS-1:0]   miss_idx_q, miss_idx_d;

    logic [IDX_BITS-1:0]   req_idx_s;
    logic [WSEL_BITS-1:0]  req_word_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic                  hit_s;
    logic                  wr_hit_s;
    logic                  fill_s;
    logic                  unused_s;

    assign req_idx_s  = p1_addr_i[OFF_BITS +: IDX_BITS];
    assign req_word_s = p1_addr_i[2 +: WSEL_BITS];
    assign req_tag_s  = p1_addr_i[31 -: TAG_BITS];
    assign unused_s   = ^p1_addr_i[1:0];

    assign hit_s      = p1_req_i & valid_q[req_idx_s] & (tag_q[req_idx_s] == req_tag_s);
    assign wr_hit_s   = hit_s & p1_write_i;
    assign p1_stall_o = p1_req_i & ~hit_s;

    // Load data path: selected word on a read hit, zero otherwise
    always_comb begin
        p1_data_o = 32'h0000_0000;
        if (hit_s && !p1_write_i) begin
            p1_data_o = data_q[req_idx_s][{req_word_s, 5'd0} +: 32];
        end else begin
            p1_data_o = 32'h0000_0000;
        end
    end

    // Miss FSM next state and memory request outputs; the missing line is latched on entry
    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        fill_s       = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = 32'h0000_0000;
        mem_data_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (p1_req_i && !hit_s) begin
                    miss_tag_d = req_tag_s;
                    miss_idx_d = req_idx_s;
                    if (valid_q[req_idx_s] && dirty_q[req_idx_s]) begin
                        state_d = ST_WRITEBACK;
                    end else begin
                        state_d = ST_ALLOCATE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, {OFF_BITS{1'b0}}};
                mem_data_o   = data_q[miss_idx_q];
                if (mem_ack_i) begin
                    state_d = ST_ALLOCATE;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b0;
                mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_BITS{1'b0}}};
                if (mem_ack_i) begin
                    fill_s  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, miss latch and line status bits; reset drops all lines including dirty ones
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
            if (wr_hit_s) begin
                dirty_q[req_idx_s] <= 1'b1;
            end
            if (fill_s) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays; a fill takes precedence over a store to the same line
    always_ff @(posedge clk_i) begin
        if (wr_hit_s) begin
            data_q[req_idx_s][{req_word_s, 5'd0} +: 32] <= p1_data_i;
        end
        if (fill_s && rst_i) begin
            data_q[miss_idx_q] <= mem_data_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios then random loads/stores,
// checked against a line-level cache/memory model held in the bench.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         p1_req_i = 1'b0;
    logic         p1_write_i = 1'b0;
    logic [31:0]  p1_addr_i = 32'h0;
    logic [31:0]  p1_data_i = 32'h0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i = 256'h0;
    logic         mem_ack_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what each of the 32 slots holds (by line address), plus backing memory
    bit           m_valid [32];
    bit           m_dirty [32];
    logic [31:0]  m_la    [32];
    logic [255:0] m_data  [32];
    logic [255:0] bk [logic [31:0]];

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] r;
        if (bk.exists(la)) begin
            r = bk[la];
        end else begin
            for (int k = 0; k < 8; k++) begin
                r[k*32 +: 32] = la * 32'h9E37_79B1 + 32'(k) * 32'h0101_0101;
            end
        end
        return r;
    endfunction

    // One memory transaction: checks the held request each cycle, acks after lat waiting cycles
    task automatic mem_phase(input bit wb, input logic [31:0] exp_addr,
                             input logic [255:0] exp_data, input logic [255:0] rdata,
                             input int lat);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk_i);
            chk1(wb ? "wb_enable" : "fill_enable", mem_enable_o, 1'b1);
            chk1(wb ? "wb_write" : "fill_write", mem_write_o, wb);
            chk32(wb ? "wb_addr" : "fill_addr", mem_addr_o, exp_addr);
            if (wb) chk256("wb_data", mem_data_o, exp_data);
            chk1("miss_wait_stall", p1_stall_o, p1_req_i);
            if (k == lat) begin
                mem_data_i = rdata;
                mem_ack_i  = 1'b1;
            end
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
    endtask

    // Full access starting just after a rising edge; drop releases the request once the miss begins
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat_wb, input int lat_fill, input bit drop);
        logic [4:0]   idx;
        logic [2:0]   w;
        logic [31:0]  la;
        logic [255:0] ln;
        bit           hit;
        idx = addr[9:5];
        w   = addr[4:2];
        la  = {addr[31:5], 5'd0};
        hit = m_valid[idx] && (m_la[idx] == la);
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wdata;
        if (!hit) begin
            @(negedge clk_i);
            chk1("miss_stall", p1_stall_o, 1'b1);
            chk32("miss_rdata", p1_data_o, 32'h0);
            @(posedge clk_i); #1;
            if (drop) p1_req_i = 1'b0;
            if (m_valid[idx] && m_dirty[idx]) begin
                mem_phase(1'b1, m_la[idx], m_data[idx], 256'h0, lat_wb);
                bk[m_la[idx]] = m_data[idx];
            end
            ln = get_line(la);
            mem_phase(1'b0, la, 256'h0, ln, lat_fill);
            m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0; m_la[idx] = la; m_data[idx] = ln;
        end
        @(negedge clk_i);
        chk1("hit_stall", p1_stall_o, 1'b0);
        chk1("hit_mem_enable", mem_enable_o, 1'b0);
        if (p1_req_i && !wr) chk32("load_data", p1_data_o, m_data[idx][int'(w)*32 +: 32]);
        else                 chk32("no_load_data", p1_data_o, 32'h0);
        @(posedge clk_i); #1;
        if (p1_req_i && wr) begin
            m_data[idx][int'(w)*32 +: 32] = wdata;
            m_dirty[idx] = 1'b1;
        end
        p1_req_i = 1'b0; p1_write_i = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    initial begin
        logic [255:0] ln;
        logic [31:0]  a;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1; rst_i = 1'b1;
        @(negedge clk_i);
        chk1("rst_stall", p1_stall_o, 1'b0);
        chk32("rst_rdata", p1_data_o, 32'h0);
        chk1("rst_mem_enable", mem_enable_o, 1'b0);
        chk1("rst_mem_write", mem_write_o, 1'b0);
        chk32("rst_mem_addr", mem_addr_o, 32'h0);
        chk256("rst_mem_data", mem_data_o, 256'h0);
        @(posedge clk_i); #1;

        // Cold read with slow fill; word0 of line 0x40 preset
        ln = get_line(32'h40);
        ln[31:0] = 32'hDEAD_BEEF;
        bk[32'h40] = ln;
        access(1'b0, 32'h0000_0040, 32'h0, 0, 10, 1'b0);
        // Write hit then read back
        access(1'b1, 32'h0000_0044, 32'h1234_5678, 0, 0, 1'b0);
        access(1'b0, 32'h0000_0044, 32'h0, 0, 0, 1'b0);
        // Dirty eviction, then clean eviction of the same slot
        access(1'b0, 32'h0000_0440, 32'h0, 2, 3, 1'b0);
        access(1'b0, 32'h0000_0840, 32'h0, 2, 1, 1'b0);
        access(1'b0, 32'h0000_0040, 32'h0, 0, 0, 1'b0);
        // Make 0x440 dirty, then reset in the middle of an unrelated fill
        access(1'b0, 32'h0000_0440, 32'h0, 0, 1, 1'b0);
        access(1'b1, 32'h0000_0448, 32'hCAFE_F00D, 0, 0, 1'b0);
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_04C0;
        @(negedge clk_i);
        chk1("pre_rst_stall", p1_stall_o, 1'b1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk1("alloc_before_rst", mem_enable_o, 1'b1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1; p1_req_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        chk1("mid_rst_mem_enable", mem_enable_o, 1'b0);
        chk1("mid_rst_mem_write", mem_write_o, 1'b0);
        chk32("mid_rst_mem_addr", mem_addr_o, 32'h0);
        chk1("mid_rst_stall", p1_stall_o, 1'b0);
        @(posedge clk_i); #1;
        // Dirty data was discarded: plain refetch, old memory contents
        access(1'b0, 32'h0000_0448, 32'h0, 0, 2, 1'b0);
        // Stray ack while idle must not disturb anything
        mem_data_i = {8{32'hBAD0_BAD0}};
        mem_ack_i  = 1'b1;
        @(negedge clk_i);
        chk1("stray_ack_stall", p1_stall_o, 1'b0);
        chk1("stray_ack_enable", mem_enable_o, 1'b0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk1("after_stray_enable", mem_enable_o, 1'b0);
        @(posedge clk_i); #1;
        access(1'b0, 32'h0000_0448, 32'h0, 0, 0, 1'b0);
        // Store miss whose request drops mid-fill: line installed, store not performed
        access(1'b1, 32'h0000_0C64, 32'h55AA_55AA, 1, 2, 1'b1);
        access(1'b0, 32'h0000_0C64, 32'h0, 0, 0, 1'b0);

        // Random loads/stores over a few indices and conflicting tags
        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 1)) << 31)
              | (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom_range(0, 15) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- MEM-stage data cache controller between EX_MEM and MEM_WB.
- Direct-mapped, write-back, write-allocate cache, 32 lines of 256 bits, in front of a line-wide data memory.
- Returns the load word that feeds MEM_WB ReadMem_i.
- Drives the pipeline-wide stall (MEM_WB stall_i, plus upstream latches) while a miss is serviced.

Parameters:
- NUM_LINES, 32, cache lines; index width = log2(NUM_LINES) = 5.
- LINE_BITS, 256, line width in bits; 8 words per line, byte offset addr[4:0].
- TAG_BITS, 22, tag width = addr[31:10] (32 - 5 index - 5 offset).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active low.
- p1_req_i  in  1  access request (MemRead | MemWrite from EX_MEM).
- p1_write_i  in  1  1 = store, 0 = load; valid with p1_req_i.
- p1_addr_i  in  32  byte address; [1:0] ignored, word aligned.
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data to MEM_WB.
- p1_stall_o  out  1  pipeline stall.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = line writeback, 0 = line fetch.
- mem_addr_o  out  32  line address, [4:0] = 0.
- mem_data_o  out  256  writeback line.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle completion pulse.

Behaviour:
Address fields:
- index = addr[9:5]; word = addr[4:2]; tag = addr[31:10].
- Per line state: valid, dirty, tag, 256-bit data.

Hit and stall:
- hit = p1_req_i & valid[index] & (tag[index] == addr tag). Combinational, same cycle.
- Read hit: p1_data_o = data[index][word*32 +: 32], same cycle. p1_data_o = 0 when there is no read hit.
- Write hit: at posedge, word updated with p1_data_i and dirty[index] = 1. No stall.
- p1_stall_o = p1_req_i & ~hit (combinational). It stays high for every cycle of miss service.
- Pipeline holds p1_* stable while stalled.

FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE: on p1_req_i & ~hit, go to WRITEBACK if the victim is valid & dirty, else go to ALLOCATE.
- WRITEBACK outputs: mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {victim tag, index, 5'b0}, mem_data_o = victim line. On mem_ack_i go to ALLOCATE.
- ALLOCATE outputs: mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {req tag, index, 5'b0}.
- ALLOCATE on mem_ack_i: line data = mem_data_i, tag = req tag, valid = 1, dirty = 0, then go to IDLE.
- Next cycle the access hits: a load returns its data with stall low; a store writes and sets dirty.
- Miss latency = (writeback mem cycles) + (fetch mem cycles) + 1 cycle.

Memory interface:
- mem_enable_o is held high until mem_ack_i. Request outputs stay stable while waiting.
- In IDLE: mem_enable_o = mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
- mem_ack_i in IDLE is ignored.

Boundary conditions:
- If p1_req_i drops mid-miss, the in-flight transaction still completes and the fill is installed. No write is performed.
- Reset (rst_i = 0 at posedge), including mid-WRITEBACK/ALLOCATE:
  - state = IDLE;
  - all valid and dirty bits = 0; dirty data is discarded;
  - all mem_* outputs = 0 from the next cycle.
- Reset values: p1_data_o = 0, p1_stall_o = 0 with p1_req_i low. Tag and data arrays need no reset.
- Store miss: allocate first, then write the word in the hit cycle. Never write around the cache.

Test Plan:
1. Cold read: reset, then load 0x0000_0040.
   - Stall and ALLOCATE with mem_addr_o = 0x40, mem_write_o = 0.
   - Ack after 10 cycles with word0 = 0xDEADBEEF.
   - Next cycle: p1_data_o = 0xDEADBEEF, stall = 0.
2. Write hit: store 0x12345678 to 0x44.
   - No stall, no mem_enable_o.
   - Load 0x44 next cycle returns 0x12345678.
3. Dirty eviction: load 0x440 (same index 2, tag 1).
   - WRITEBACK at 0x40 with mem_data_o[63:32] = 0x12345678 and word0 = 0xDEADBEEF.
   - Then ALLOCATE at 0x440, then hit.
4. Clean eviction: load 0x840 after case 3.
   - ALLOCATE at 0x840 directly; no mem_write_o = 1 cycle.
5. Reset mid-ALLOCATE: assert rst_i = 0 during ALLOCATE.
   - mem_enable_o = 0 next cycle.
   - Re-reading the previously cached 0x440 misses.
6. Stray mem_ack_i pulse in IDLE: no state change, no array update, stall stays 0.
